// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forward-select encoding, register address width
// and the hazard controller state encoding.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'b00,
    HZ_LOAD_STALL = 2'b01,
    HZ_MEM_WAIT   = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forward-select compare for one EX operand. The youngest producer (MEM)
// wins over the older one (WB) when both target the same register.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::REG_ADDR_W
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  output logic [1:0]    sel
);

  // mem_we/wb_we are already cleared for x0 writes, so x0 never forwards
  always_comb begin
    sel = FWD_REG;
    if (mem_we && (mem_rd == src))     sel = FWD_MEM;
    else if (wb_we && (wb_rd == src))  sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flush, data
// memory freeze and EX operand forward selects. Tracks MEM/WB destinations
// in local shadow registers.
// Build option HAZARD_FORWARDING_EN: when defined, operands are forwarded
// and only load-use stalls; when undefined, forward selects are tied to
// regfile and any pending write to a used ID source stalls until it retires.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write_en,
  input  logic                  ex_mem_read_en,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  hz_state_t             state, state_nx;
  logic [REG_ADDR_W-1:0] mem_rd, wb_rd;
  logic                  mem_we, wb_we;
  logic                  hold;
  logic                  hz;

  // Shadow MEM/WB destinations; they move with EX/MEM and freeze with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else if (!ex_mem_stall) begin
      mem_rd <= ex_rd_addr;
      mem_we <= ex_reg_write_en & (ex_rd_addr != '0);
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HZ_RUN;
    else     state <= state_nx;
  end

  // Frozen while waiting on memory; elsewhere a new miss starts the freeze
  assign hold = (state == HZ_MEM_WAIT) ? ~mem_ready : (mem_req & ~mem_ready);

`ifdef HAZARD_FORWARDING_EN
  logic load_use;
  assign load_use = ex_mem_read_en & ex_reg_write_en & (ex_rd_addr != '0) &
                    ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                     (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
  // The bubble sits in EX during LOAD_STALL, so the load cannot re-trigger
  assign hz = load_use & (state != HZ_LOAD_STALL);

  logic [1:0][REG_ADDR_W-1:0] ex_src;
  logic [1:0][1:0]            fwd_sel;
  assign ex_src = {ex_rs2_addr, ex_rs1_addr};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    fwd_unit #(.AW(REG_ADDR_W)) u_fwd (
      .src    (ex_src[i]),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd_sel[i])
    );
  end

  assign fwd_a_sel = fwd_sel[0];
  assign fwd_b_sel = fwd_sel[1];
`else
  // No write-through regfile: any in-flight write to a used source blocks ID
  logic raw1, raw2;
  assign raw1 = id_rs1_used & (id_rs1_addr != '0) &
                ((ex_reg_write_en & (ex_rd_addr == id_rs1_addr)) |
                 (mem_we & (mem_rd == id_rs1_addr)) |
                 (wb_we & (wb_rd == id_rs1_addr)));
  assign raw2 = id_rs2_used & (id_rs2_addr != '0) &
                ((ex_reg_write_en & (ex_rd_addr == id_rs2_addr)) |
                 (mem_we & (mem_rd == id_rs2_addr)) |
                 (wb_we & (wb_rd == id_rs2_addr)));
  assign hz = raw1 | raw2;

  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;

  logic unused_nofwd;
  assign unused_nofwd = ^{ex_rs1_addr, ex_rs2_addr, ex_mem_read_en};
`endif

  // Next state and control outputs; freeze > flush > hazard stall
  always_comb begin
    state_nx     = state;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    if (!rst) begin
      if (hold) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        state_nx     = HZ_MEM_WAIT;
      end else if (ex_branch_taken) begin
        // ID holds a wrong-path instruction, so flushing beats any stall
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_nx     = HZ_RUN;
      end else if (hz) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
`ifdef HAZARD_FORWARDING_EN
        state_nx     = (state == HZ_RUN) ? HZ_LOAD_STALL : HZ_RUN;
`else
        state_nx     = HZ_RUN;
`endif
      end else begin
        state_nx     = HZ_RUN;
      end
    end
  end

endmodule
